// File: rtl/dt1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dt1_mem_arbiter
//
// Shares the single unified instruction/data memory port of the RV32i core
// between the fetch stage and the memory stage. Each access is granted in an
// IDLE cycle, issued on the memory port as a one-cycle mreq strobe, and its
// response is returned on ivalid/dvalid MEM_LATENCY cycles after the strobe.
// Data accesses normally win over fetches; a starve counter forces a fetch
// grant after STARVE_LIMIT consecutive data grants while fetch is waiting.
//
// FSM
//   state | meaning
//   IDLE  | no access in flight; arbitrate and grant this cycle
//   WAIT  | access in flight; mreq in the first cycle, response in the last
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   ireq, iaddr            fetch request / word address
//   ivalid, irdata         fetch response pulse / instruction word
//   dreq, daddr, dwrite,   data request / address / store flag /
//   dsize, dwdata          funct3 size code / store data
//   dvalid, drdata         data response pulse / raw load word
//   mreq, maddr, mwe,      memory strobe / address / write enable /
//   msize, mwdata, mrdata  size code / write data / read data
//   StallF, StallM         stall requests to the hazard unit
// -----------------------------------------------------------------------------
module dt1_mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        ivalid,
    output logic [31:0] irdata,

    input  logic        dreq,
    input  logic [31:0] daddr,
    input  logic        dwrite,
    input  logic [2:0]  dsize,
    input  logic [31:0] dwdata,
    output logic        dvalid,
    output logic [31:0] drdata,

    output logic        mreq,
    output logic [31:0] maddr,
    output logic        mwe,
    output logic [2:0]  msize,
    output logic [31:0] mwdata,
    input  logic [31:0] mrdata,

    output logic        StallF,
    output logic        StallM
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    // owner: 0 = fetch, 1 = data
    state_t      state_q,  state_d;
    logic        owner_q,  owner_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] maddr_q,  maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [2:0]  msize_q,  msize_d;
    logic        we_q,     we_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;

    logic grant_i;
    logic grant_d;
    logic issue;
    logic resp;

    // Arbitration happens only in IDLE. Data has priority unless fetch has
    // been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (ireq && (!dreq || (starve_q == STARVE_MAX))) begin
                grant_i = 1'b1;
            end else if (dreq) begin
                grant_d = 1'b1;
            end
        end
    end

    // The counter is loaded with MEM_LATENCY at the grant edge, so the strobe
    // cycle is the one where it still holds the load value and the response
    // cycle is the one where it has run down to zero.
    always_comb begin
        issue  = (state_q == WAIT) && (cnt_q == LAT_INIT);
        resp   = (state_q == WAIT) && (cnt_q == 4'd0);
        mreq   = issue;
        mwe    = issue & we_q;
        maddr  = maddr_q;
        msize  = msize_q;
        mwdata = mwdata_q;
        ivalid = resp & ~owner_q;
        dvalid = resp &  owner_q;
        // Response data is forwarded straight from memory in the valid cycle
        // and held from the register afterwards.
        irdata = ivalid ? mrdata : irdata_q;
        drdata = (dvalid && !we_q) ? mrdata : drdata_q;
        StallF = ireq & ~ivalid;
        StallM = dreq & ~dvalid;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        msize_d  = msize_q;
        we_d     = we_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = WAIT;
                    owner_d  = 1'b0;
                    cnt_d    = LAT_INIT;
                    maddr_d  = iaddr;
                    mwdata_d = 32'h0;
                    msize_d  = SIZE_WORD;
                    we_d     = 1'b0;
                end else if (grant_d) begin
                    state_d  = WAIT;
                    owner_d  = 1'b1;
                    cnt_d    = LAT_INIT;
                    maddr_d  = daddr;
                    mwdata_d = dwdata;
                    msize_d  = dsize;
                    we_d     = dwrite;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Starve counter tracks consecutive data grants with fetch waiting.
    always_comb begin
        starve_d = starve_q;
        if (!ireq || grant_i) begin
            starve_d = 4'd0;
        end else if (grant_d && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        if (ivalid) begin
            irdata_d = mrdata;
        end
        if (dvalid && !we_q) begin
            drdata_d = mrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            cnt_q    <= 4'd0;
            starve_q <= 4'd0;
            maddr_q  <= 32'h0;
            mwdata_q <= 32'h0;
            msize_q  <= 3'b000;
            we_q     <= 1'b0;
            irdata_q <= 32'h0;
            drdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            msize_q  <= msize_d;
            we_q     <= we_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

endmodule

// File: tb/tb_dt1_mem_arbiter.sv
module tb_dt1_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
    } macc_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq = 1'b0, dreq = 1'b0, dwrite = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
    logic [2:0]  dsize = '0;
    logic        ivalid, dvalid, mreq, mwe, StallF, StallM;
    logic [31:0] irdata, drdata, maddr, mwdata, mrdata;
    logic [2:0]  msize;

    // second instance: MEM_LATENCY = 1
    logic        reset1 = 1'b1;
    logic        ireq1 = 1'b0;
    logic [31:0] iaddr1 = '0;
    logic        ivalid1, dvalid1, mreq1, mwe1, StallF1, StallM1;
    logic [31:0] irdata1, drdata1, maddr1, mwdata1, mrdata1;
    logic [2:0]  msize1;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int mreq_cyc = 0;

    macc_t mq[$];
    resp_t rq[$];
    logic [31:0] exp_drdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dt1_mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .ivalid(ivalid), .irdata(irdata),
        .dreq(dreq), .daddr(daddr), .dwrite(dwrite), .dsize(dsize), .dwdata(dwdata),
        .dvalid(dvalid), .drdata(drdata),
        .mreq(mreq), .maddr(maddr), .mwe(mwe), .msize(msize), .mwdata(mwdata), .mrdata(mrdata),
        .StallF(StallF), .StallM(StallM)
    );

    dt1_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset1),
        .ireq(ireq1), .iaddr(iaddr1), .ivalid(ivalid1), .irdata(irdata1),
        .dreq(1'b0), .daddr(32'h0), .dwrite(1'b0), .dsize(3'b000), .dwdata(32'h0),
        .dvalid(dvalid1), .drdata(drdata1),
        .mreq(mreq1), .maddr(maddr1), .mwe(mwe1), .msize(msize1), .mwdata(mwdata1), .mrdata(mrdata1),
        .StallF(StallF1), .StallM(StallM1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory models: data appears exactly MEM_LATENCY cycles after mreq,
    // garbage otherwise.
    logic        m_seen = 1'b0, m1_seen = 1'b0;
    logic [31:0] m_addr = '0, m1_addr = '0;
    logic        pv0 = 1'b0, pv1 = 1'b0, qv0 = 1'b0;
    logic [31:0] pd0 = '0, pd1 = '0, qd0 = '0;

    always @(negedge clk) begin
        m_seen  = mreq;
        m_addr  = maddr;
        m1_seen = mreq1;
        m1_addr = maddr1;
    end

    always @(posedge clk) begin
        pv0 <= m_seen;
        pd0 <= mem_word(m_addr);
        pv1 <= pv0;
        pd1 <= pd0;
        qv0 <= m1_seen;
        qd0 <= mem_word(m1_addr);
    end

    assign mrdata  = pv1 ? pd1 : 32'hBAD0_BAD0;
    assign mrdata1 = qv0 ? qd0 : 32'hBAD1_BAD1;

    // Scoreboard monitor for the MEM_LATENCY=2 instance.
    always @(negedge clk) begin
        macc_t e;
        resp_t r;
        if (!reset) begin
            if (ivalid && dvalid) chk("valid_overlap", 32'd1, 32'd0);
            if (mreq) begin
                if (mq.size() == 0) begin
                    chk("mreq_unexpected", 32'd1, 32'd0);
                end else begin
                    e = mq.pop_front();
                    chk("maddr", maddr, e.addr);
                    chk("mwe", {31'd0, mwe}, {31'd0, e.we});
                    chk("msize", {29'd0, msize}, {29'd0, e.size});
                    if (e.we) chk("mwdata", mwdata, e.wdata);
                end
                mreq_cyc = cyc;
            end
            if (ivalid || dvalid) begin
                if (rq.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("valid_port", {31'd0, dvalid}, {31'd0, r.is_d});
                    chk("rdata", dvalid ? drdata : irdata, r.data);
                    chk("valid_latency", cyc - mreq_cyc, 32'd2);
                end
                if (dvalid && ireq) chk("stallF_during_data", {31'd0, StallF}, 32'd1);
            end
        end
    end

    task automatic expect_acc(input logic is_d, input logic [31:0] a, input logic we,
                              input logic [2:0] sz, input logic [31:0] wd, input logic want_resp);
        macc_t e;
        resp_t r;
        e.addr = a; e.we = we; e.size = is_d ? sz : 3'b010; e.wdata = wd;
        mq.push_back(e);
        if (want_resp) begin
            r.is_d = is_d;
            if (!is_d) r.data = mem_word(a);
            else if (!we) begin
                exp_drdata = mem_word(a);
                r.data = exp_drdata;
            end else r.data = exp_drdata;
            rq.push_back(r);
        end
    endtask

    task automatic wait_valid(input logic is_d);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (is_d) begin
                chk("stallM", {31'd0, StallM}, {31'd0, ~dvalid});
                seen = dvalid;
            end else begin
                chk("stallF", {31'd0, StallF}, {31'd0, ~ivalid});
                seen = ivalid;
            end
        end
        if (!seen) chk(is_d ? "dvalid_timeout" : "ivalid_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_i(input logic [31:0] a);
        ireq = 1'b1; iaddr = a;
        wait_valid(1'b0);
        ireq = 1'b0;
    endtask

    task automatic run_d(input logic [31:0] a, input logic we, input logic [2:0] sz, input logic [31:0] wd);
        dreq = 1'b1; daddr = a; dwrite = we; dsize = sz; dwdata = wd;
        wait_valid(1'b1);
        dreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [31:0] a;
        int          got, last_m, nval;
        logic [31:0] q1[$];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_mreq", {31'd0, mreq}, 32'd0);
        chk("rst_valid", {30'd0, ivalid, dvalid}, 32'd0);
        chk("rst_maddr", maddr, 32'd0);
        chk("rst_msize", {29'd0, msize}, 32'd0);
        chk("rst_irdata", irdata, 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        @(posedge clk); #1;

        // fetch only: grant cycle, then strobe
        expect_acc(1'b0, 32'h100, 1'b0, 3'b010, 32'h0, 1'b1);
        ireq = 1'b1; iaddr = 32'h100;
        @(negedge clk);
        chk("grant_cycle_mreq", {31'd0, mreq}, 32'd0);
        chk("grant_cycle_stallF", {31'd0, StallF}, 32'd1);
        @(negedge clk);
        chk("issue_cycle_mreq", {31'd0, mreq}, 32'd1);
        wait_valid(1'b0);
        ireq = 1'b0;
        @(negedge clk);
        chk("irdata_held", irdata, 32'h00500093);
        @(posedge clk); #1;

        // load then store; store must leave drdata alone
        expect_acc(1'b1, 32'h3000, 1'b0, 3'b010, 32'h0, 1'b1);
        run_d(32'h3000, 1'b0, 3'b010, 32'h0);
        expect_acc(1'b1, 32'h2004, 1'b1, 3'b010, 32'hDEADBEEF, 1'b1);
        run_d(32'h2004, 1'b1, 3'b010, 32'hDEADBEEF);
        @(negedge clk);
        chk("drdata_after_store", drdata, mem_word(32'h3000));
        @(posedge clk); #1;

        // simultaneous fetch and load: data first
        expect_acc(1'b1, 32'h3010, 1'b0, 3'b000, 32'h0, 1'b1);
        expect_acc(1'b0, 32'h200, 1'b0, 3'b010, 32'h0, 1'b1);
        fork
            run_d(32'h3010, 1'b0, 3'b000, 32'h0);
            run_i(32'h200);
        join
        repeat (2) @(posedge clk); #1;

        // starvation: D,D,D,D,I,D with dreq held throughout
        for (int k = 0; k < 4; k++)
            expect_acc(1'b1, 32'h4000 + 32'(k * 4), 1'b0, 3'b010, 32'h0, 1'b1);
        expect_acc(1'b0, 32'h300, 1'b0, 3'b010, 32'h0, 1'b1);
        expect_acc(1'b1, 32'h4010, 1'b0, 3'b101, 32'h0, 1'b1);
        fork
            begin
                for (int k = 0; k < 4; k++) run_d(32'h4000 + 32'(k * 4), 1'b0, 3'b010, 32'h0);
                run_d(32'h4010, 1'b0, 3'b101, 32'h0);
            end
            run_i(32'h300);
        join
        // starve count cleared: a new contended pair goes to data first again
        expect_acc(1'b1, 32'h4020, 1'b0, 3'b010, 32'h0, 1'b1);
        expect_acc(1'b0, 32'h304, 1'b0, 3'b010, 32'h0, 1'b1);
        fork
            run_d(32'h4020, 1'b0, 3'b010, 32'h0);
            run_i(32'h304);
        join
        repeat (2) @(posedge clk); #1;

        // reset one cycle after mreq: response discarded
        expect_acc(1'b0, 32'h500, 1'b0, 3'b010, 32'h0, 1'b0);
        ireq = 1'b1; iaddr = 32'h500;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = mreq;
        end
        if (!found) chk("rst_test_mreq_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; ireq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_drdata = 32'h0;
        @(negedge clk);
        chk("postrst_valid", {30'd0, ivalid, dvalid}, 32'd0);
        chk("postrst_mreq", {31'd0, mreq}, 32'd0);
        chk("postrst_maddr", maddr, 32'd0);
        chk("postrst_mwdata", mwdata, 32'd0);
        chk("postrst_irdata", irdata, 32'd0);
        chk("postrst_drdata", drdata, 32'd0);
        nval = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ivalid || dvalid) nval++;
        end
        chk("postrst_no_valid", 32'(nval), 32'd0);
        @(posedge clk); #1;
        expect_acc(1'b0, 32'h104, 1'b0, 3'b010, 32'h0, 1'b1);
        run_i(32'h104);
        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(mq.size() + rq.size()), 32'd0);

        // MEM_LATENCY=1 instance: fetches at 0x0, 0x4, 0x8
        #1 reset1 = 1'b0;
        q1.push_back(32'h0); q1.push_back(32'h4); q1.push_back(32'h8);
        ireq1 = 1'b1; iaddr1 = 32'h0;
        got = 0; last_m = -1;
        for (int k = 0; k < 60 && got < 3; k++) begin
            @(negedge clk);
            if (mreq1) begin
                if (q1.size() > 0) chk("l1_maddr", maddr1, q1[0]);
                if (last_m >= 0) chk("l1_period", 32'(cyc - last_m), 32'd3);
                last_m = cyc;
            end
            if (ivalid1) begin
                if (q1.size() == 0) begin
                    chk("l1_spurious", 32'd1, 32'd0);
                end else begin
                    a = q1.pop_front();
                    chk("l1_latency", 32'(cyc - last_m), 32'd1);
                    chk("l1_irdata", irdata1, mem_word(a));
                end
                got++;
                @(posedge clk); #1;
                if (q1.size() > 0) iaddr1 = q1[0];
                else ireq1 = 1'b0;
            end
        end
        chk("l1_count", 32'(got), 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
